mem_dma: RTL and testbench

//  Bus initiator for the single-port word memory: copies LEN words from SRC to DST, or fills
//  LEN words at DST with a constant. Sits between the control/CPU logic and the memory,

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_dma_addr_gen.sv | 44 ++++
 rtl/mem_dma.sv | 156 +++++++++++++++
 tb/tb_mem_dma.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-bus constants and DMA state encoding
package mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    RD,
    WR,
    DONE
  } state_e;

endpackage

// File: rtl/mem_dma_addr_gen.sv
// rtl/mem_dma_addr_gen.sv - word index counter (up/down) with source/destination address adders
module mem_dma_addr_gen
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  desc_i,
  input  logic [MEM_ADDR_W-1:0] len_i,
  input  logic [MEM_ADDR_W-1:0] src_i,
  input  logic [MEM_ADDR_W-1:0] dst_i,
  output logic [MEM_ADDR_W-1:0] rd_addr_o,
  output logic [MEM_ADDR_W-1:0] wr_addr_o,
  output logic                  last_o
);

  localparam logic [MEM_ADDR_W-1:0] ONE = MEM_ADDR_W'(1);

  logic [MEM_ADDR_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = desc_i ? (len_i - ONE) : '0;
    end else if (step_i) begin
      idx_d = desc_i ? (idx_q - ONE) : (idx_q + ONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Addresses follow the next index so the top can register them for the coming cycle.
  assign rd_addr_o = src_i + idx_d;
  assign wr_addr_o = dst_i + idx_d;
  assign last_o    = desc_i ? (idx_q == '0) : (idx_q == (len_i - ONE));

endmodule

// File: rtl/mem_dma.sv
// rtl/mem_dma.sv - memory copy/fill bus initiator with range check and memmove ordering
module mem_dma
  import mem_pkg::*;
#(
  parameter int MEM_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  fill,
  input  logic [MEM_ADDR_W-1:0] src,
  input  logic [MEM_ADDR_W-1:0] dst,
  input  logic [MEM_ADDR_W-1:0] len,
  input  logic [MEM_DATA_W-1:0] fill_val,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [MEM_ADDR_W-1:0] address,
  output logic [MEM_DATA_W-1:0] data,
  output logic                  memW,
  output logic                  memR,
  input  logic [MEM_DATA_W-1:0] readData
);

  localparam logic [MEM_ADDR_W:0] MEM_LIMIT = (MEM_ADDR_W + 1)'(MEM_SIZE);

  state_e state_q, state_d;

  logic                  fill_q;
  logic [MEM_ADDR_W-1:0] src_q, dst_q, len_q;
  logic [MEM_DATA_W-1:0] fval_q;
  logic [MEM_DATA_W-1:0] buf_q, buf_d;
  logic [MEM_ADDR_W-1:0] address_q, address_d;
  logic [MEM_DATA_W-1:0] data_q, data_d;
  logic                  memw_q, memw_d, memr_q, memr_d;
  logic                  busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic [MEM_ADDR_W:0]   src_end, dst_end;
  logic                  range_err, desc, last;
  logic [MEM_ADDR_W-1:0] rd_addr, wr_addr;
  logic                  accept;

  assign accept    = (state_q == IDLE) && start;
  assign src_end   = {1'b0, src_q} + {1'b0, len_q};
  assign dst_end   = {1'b0, dst_q} + {1'b0, len_q};
  assign range_err = (dst_end > MEM_LIMIT) || (!fill_q && (src_end > MEM_LIMIT));
  // Destination overlapping the tail of the source must be walked top-down.
  assign desc      = !fill_q && (dst_q > src_q) && ({1'b0, dst_q} < src_end);

  mem_dma_addr_gen u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load_i    (state_q == CHK),
    .step_i    ((state_q == WR) && !last),
    .desc_i    (desc),
    .len_i     (len_q),
    .src_i     (src_q),
    .dst_i     (dst_q),
    .rd_addr_o (rd_addr),
    .wr_addr_o (wr_addr),
    .last_o    (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = CHK;
      CHK: begin
        if (range_err || (len_q == '0)) state_d = DONE;
        else if (fill_q)                state_d = WR;
        else                            state_d = RD;
      end
      RD:   state_d = WR;
      WR: begin
        if (last)        state_d = DONE;
        else if (fill_q) state_d = WR;
        else             state_d = RD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered strobes line up with it.
  always_comb begin
    buf_d     = (state_q == RD) ? readData : buf_q;
    address_d = address_q;
    data_d    = data_q;
    memr_d    = (state_d == RD);
    memw_d    = (state_d == WR);
    busy_d    = memr_d || memw_d;
    done_d    = (state_d == DONE);
    error_d   = error_q;
    if (accept) error_d = 1'b0;
    if ((state_q == CHK) && range_err) error_d = 1'b1;
    case (state_d)
      RD: address_d = rd_addr;
      WR: begin
        address_d = wr_addr;
        data_d    = fill_q ? fval_q : buf_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      fval_q    <= '0;
      buf_q     <= '0;
      address_q <= '0;
      data_q    <= '0;
      memw_q    <= 1'b0;
      memr_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      if (accept) begin
        fill_q <= fill;
        src_q  <= src;
        dst_q  <= dst;
        len_q  <= len;
        fval_q <= fill_val;
      end
      buf_q     <= buf_d;
      address_q <= address_d;
      data_q    <= data_d;
      memw_q    <= memw_d;
      memr_q    <= memr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign address = address_q;
  assign data    = data_q;
  assign memW    = memw_q;
  assign memR    = memr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_mem_dma.sv
// tb/tb_mem_dma.sv - scoreboard bench for mem_dma with a behavioural word memory
module tb_mem_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        fill = 1'b0;
  logic [31:0] src = '0, dst = '0, len = '0, fill_val = '0;
  logic        busy, done, error, memW, memR;
  logic [31:0] address, data, readData;

  logic [31:0] mem [32];
  logic [31:0] exp_mem [32];
  logic [31:0] pre_mem [32];

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  int          vectors = 0;
  int          miscompares = 0;
  int          rd_cnt = 0, wr_cnt = 0;
  logic [31:0] first_wr = '0;
  logic        pend_w = 1'b0;
  logic [31:0] pend_a = '0, pend_d = '0;

  assign readData = (address < 32) ? mem[address[4:0]] : 32'h0;

  always #5 clk = ~clk;

  mem_dma #(.MEM_SIZE(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .fill     (fill),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .fill_val (fill_val),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .address  (address),
    .data     (data),
    .memW     (memW),
    .memR     (memR),
    .readData (readData)
  );

  // One clock: commit the write of the cycle just closed, then observe the new cycle's bus.
  task automatic cycle();
    wr_t e;
    @(posedge clk);
    #1;
    if (pend_w) mem[pend_a[4:0]] = pend_d;
    pend_w = 1'b0;
    if (memR && memW) begin
      vectors++; miscompares++;
      $display("FAIL strobe_excl: memR=%0b memW=%0b both high", memR, memW);
    end
    if (memR) rd_cnt++;
    if (memW) begin
      if (wr_cnt == 0) first_wr = address;
      wr_cnt++;
      pend_w = 1'b1; pend_a = address; pend_d = data;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_write: unexpected write addr=%0d data=%h, none required", address, data);
      end else begin
        e = exp_q.pop_front();
        if (address !== e.a || data !== e.d) begin
          miscompares++;
          $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   address, data, e.a, e.d);
        end
      end
    end
  endtask

  task automatic expect_copy(input int s, input int d, input int l);
    logic [31:0] tmp [32];
    bit desc;
    int idx;
    desc = (d > s) && (d < s + l);
    for (int i = 0; i < 32; i++) begin
      exp_mem[i] = mem[i];
      pre_mem[i] = mem[i];
    end
    for (int k = 0; k < l; k++) tmp[k] = mem[s + k];
    for (int k = 0; k < l; k++) begin
      idx = desc ? (l - 1 - k) : k;
      exp_q.push_back({32'(d + idx), tmp[idx]});
      exp_mem[d + k] = tmp[k];
    end
  endtask

  task automatic expect_fill(input int d, input int l, input logic [31:0] v);
    for (int i = 0; i < 32; i++) begin
      exp_mem[i] = mem[i];
      pre_mem[i] = mem[i];
    end
    for (int k = 0; k < l; k++) begin
      exp_q.push_back({32'(d + k), v});
      exp_mem[d + k] = v;
    end
  endtask

  task automatic run_req(input bit f, input int s, input int d, input int l,
                         input logic [31:0] v, output int lat);
    fill = f; src = 32'(s); dst = 32'(d); len = 32'(l); fill_val = v;
    start = 1'b1;
    rd_cnt = 0; wr_cnt = 0;
    cycle();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      cycle();
      lat++;
    end
    if (lat >= 200) begin
      vectors++; miscompares++;
      $display("FAIL timeout: no done within %0d cycles", lat);
    end
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) cycle();
    vectors += 7;
    if (busy !== 1'b0)   begin miscompares++; $display("FAIL rst_busy: got %b need 0", busy); end
    if (done !== 1'b0)   begin miscompares++; $display("FAIL rst_done: got %b need 0", done); end
    if (error !== 1'b0)  begin miscompares++; $display("FAIL rst_error: got %b need 0", error); end
    if (memW !== 1'b0)   begin miscompares++; $display("FAIL rst_memW: got %b need 0", memW); end
    if (memR !== 1'b0)   begin miscompares++; $display("FAIL rst_memR: got %b need 0", memR); end
    if (address !== 0)   begin miscompares++; $display("FAIL rst_addr: got %h need 0", address); end
    if (data !== 0)      begin miscompares++; $display("FAIL rst_data: got %h need 0", data); end
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_copy();
    int lat;
    mem[0] = 32'hAAAA_0001; mem[1] = 32'hBBBB_0002; mem[2] = 32'hCCCC_0003; mem[3] = 32'hDDDD_0004;
    expect_copy(0, 16, 4);
    run_req(1'b0, 0, 16, 4, 32'h0, lat);
    vectors += 3;
    if (lat !== 9) begin miscompares++; $display("FAIL copy_latency: got %0d need 9", lat); end
    if (rd_cnt !== 4 || wr_cnt !== 4) begin
      miscompares++; $display("FAIL copy_beats: got rd=%0d wr=%0d need 4/4", rd_cnt, wr_cnt);
    end
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL copy_sb_left: got %0d need 0", exp_q.size()); end
    for (int k = 16; k < 20; k++) begin
      vectors++;
      if (mem[k] !== exp_mem[k]) begin
        miscompares++; $display("FAIL copy_mem[%0d]: got %h need %h", k, mem[k], exp_mem[k]);
      end
    end
  endtask

  task automatic test_overlap();
    int lat;
    for (int k = 0; k < 4; k++) mem[2 + k] = 32'(k + 1);
    expect_copy(2, 4, 4);
    run_req(1'b0, 2, 4, 4, 32'h0, lat);
    vectors += 3;
    if (lat !== 9) begin miscompares++; $display("FAIL ovl_latency: got %0d need 9", lat); end
    if (first_wr !== 7) begin miscompares++; $display("FAIL ovl_first_wr: got %0d need 7", first_wr); end
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL ovl_sb_left: got %0d need 0", exp_q.size()); end
    for (int k = 4; k < 8; k++) begin
      vectors++;
      if (mem[k] !== 32'(k - 3)) begin
        miscompares++; $display("FAIL ovl_mem[%0d]: got %h need %h", k, mem[k], 32'(k - 3));
      end
    end
  endtask

  task automatic test_fill();
    int lat;
    expect_fill(30, 2, 32'hDEAD_BEEF);
    run_req(1'b1, 0, 30, 2, 32'hDEAD_BEEF, lat);
    vectors += 3;
    if (lat !== 3) begin miscompares++; $display("FAIL fill_latency: got %0d need 3", lat); end
    if (rd_cnt !== 0) begin miscompares++; $display("FAIL fill_reads: got %0d need 0", rd_cnt); end
    if (wr_cnt !== 2) begin miscompares++; $display("FAIL fill_writes: got %0d need 2", wr_cnt); end
    for (int k = 30; k < 32; k++) begin
      vectors++;
      if (mem[k] !== 32'hDEAD_BEEF) begin
        miscompares++; $display("FAIL fill_mem[%0d]: got %h need deadbeef", k, mem[k]);
      end
    end
  endtask

  task automatic test_error();
    int lat;
    run_req(1'b1, 0, 30, 3, 32'h1234_5678, lat);
    vectors += 3;
    if (lat !== 1) begin miscompares++; $display("FAIL err_latency: got %0d need 1", lat); end
    if (rd_cnt + wr_cnt !== 0) begin
      miscompares++; $display("FAIL err_bus: got rd=%0d wr=%0d need 0/0", rd_cnt, wr_cnt);
    end
    if (error !== 1'b1) begin miscompares++; $display("FAIL err_flag: got %b need 1", error); end
    repeat (3) cycle();
    vectors++;
    if (error !== 1'b1) begin miscompares++; $display("FAIL err_held: got %b need 1", error); end
    expect_fill(0, 1, 32'h0BAD_F00D);
    run_req(1'b1, 0, 0, 1, 32'h0BAD_F00D, lat);
    vectors += 3;
    if (error !== 1'b0) begin miscompares++; $display("FAIL err_clear: got %b need 0", error); end
    if (lat !== 2) begin miscompares++; $display("FAIL err_next_latency: got %0d need 2", lat); end
    if (mem[0] !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL err_next_mem: got %h need 0badf00d", mem[0]); end
  endtask

  task automatic test_len0_busy();
    int lat;
    run_req(1'b0, 0, 5, 0, 32'h0, lat);
    vectors += 3;
    if (lat !== 1) begin miscompares++; $display("FAIL len0_latency: got %0d need 1", lat); end
    if (error !== 1'b0) begin miscompares++; $display("FAIL len0_error: got %b need 0", error); end
    if (rd_cnt + wr_cnt !== 0) begin
      miscompares++; $display("FAIL len0_bus: got rd=%0d wr=%0d need 0/0", rd_cnt, wr_cnt);
    end
    expect_copy(8, 20, 2);
    fill = 1'b0; src = 32'd8; dst = 32'd20; len = 32'd2; fill_val = 32'h0;
    rd_cnt = 0; wr_cnt = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 1) begin
        start = 1'b1; fill = 1'b1; dst = 32'd0; len = 32'd1; fill_val = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
      end
      cycle();
      lat++;
    end
    start = 1'b0;
    cycle();
    vectors += 3;
    if (lat !== 5) begin miscompares++; $display("FAIL busy_latency: got %0d need 5", lat); end
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL busy_sb_left: got %0d need 0", exp_q.size()); end
    if (mem[0] !== exp_mem[0]) begin miscompares++; $display("FAIL busy_ignored: mem[0] got %h need %h", mem[0], exp_mem[0]); end
    for (int k = 20; k < 22; k++) begin
      vectors++;
      if (mem[k] !== exp_mem[k]) begin
        miscompares++; $display("FAIL busy_mem[%0d]: got %h need %h", k, mem[k], exp_mem[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int lat;
    for (int k = 0; k < 4; k++) mem[k] = 32'h7700_0000 + 32'(k);
    expect_copy(0, 8, 4);
    fill = 1'b0; src = 32'd0; dst = 32'd8; len = 32'd4;
    rd_cnt = 0; wr_cnt = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    n = 0;
    while (wr_cnt < 2 && n < 50) begin
      cycle();
      n++;
    end
    vectors++;
    if (wr_cnt < 2) begin miscompares++; $display("FAIL rmid_wait: got %0d writes need 2", wr_cnt); end
    pend_w = 1'b0;
    exp_q.delete();
    reset = 1'b0;
    #1;
    vectors += 3;
    if (memW !== 1'b0) begin miscompares++; $display("FAIL rmid_memW: got %b need 0", memW); end
    if (memR !== 1'b0) begin miscompares++; $display("FAIL rmid_memR: got %b need 0", memR); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b need 0", busy); end
    cycle();
    reset = 1'b1;
    cycle();
    vectors++;
    if (mem[8] !== exp_mem[8]) begin miscompares++; $display("FAIL rmid_word0: got %h need %h", mem[8], exp_mem[8]); end
    for (int k = 9; k < 12; k++) begin
      vectors++;
      if (mem[k] !== pre_mem[k]) begin
        miscompares++; $display("FAIL rmid_untouched[%0d]: got %h need %h", k, mem[k], pre_mem[k]);
      end
    end
    expect_copy(0, 24, 3);
    run_req(1'b0, 0, 24, 3, 32'h0, lat);
    vectors += 2;
    if (lat !== 7) begin miscompares++; $display("FAIL rmid_next_latency: got %0d need 7", lat); end
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL rmid_sb_left: got %0d need 0", exp_q.size()); end
    for (int k = 24; k < 27; k++) begin
      vectors++;
      if (mem[k] !== exp_mem[k]) begin
        miscompares++; $display("FAIL rmid_mem[%0d]: got %h need %h", k, mem[k], exp_mem[k]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h5000_0000 + 32'(i);
    test_reset();
    test_copy();
    test_overlap();
    test_fill();
    test_error();
    test_len0_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
